// File: rtl/ysyx_25030093_pc_gen.sv
// Next-PC generator: holds the architectural PC, hands it to fetch and takes one
// commit per instruction. Also flags misaligned or illegal targets and tracks calls/returns.
module ysyx_25030093_pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 'h2000_0000,
  parameter int              RAS_DEPTH = 4,
  parameter bit              C_EXT     = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      pc_sel,
  input  logic            br_taken,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] imm_data,
  input  logic [XLEN-1:0] csr_data_pc,
  input  logic [XLEN-1:0] mtvec,
  input  logic            is_call,
  input  logic            is_ret,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr,
  output logic            illegal_sel,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid,
  output logic            ras_overflow
);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(4);

  typedef enum logic {ISSUE = 1'b0, WAIT = 1'b1} state_t;

  state_t state_q;
  logic [XLEN-1:0] pc_q;

  logic [RAS_DEPTH-1:0][XLEN-1:0] ras_q;
  logic [PW-1:0] ptr_q;    // next slot to write
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] top_idx;

  logic            accept, legal, chk, mis;
  logic [XLEN-1:0] tgt, link;

  assign accept  = (state_q == WAIT) && in_valid;
  assign link    = pc_q + STEP;
  assign top_idx = ptr_q - PW'(1);

  always_comb begin
    tgt   = pc_q;
    legal = 1'b1;
    chk   = 1'b1;
    unique case (pc_sel)
      3'b001:  tgt = (rs1_data + imm_data) & {{(XLEN-1){1'b1}}, 1'b0};
      3'b010:  tgt = pc_q + imm_data;
      3'b100: begin
        tgt = br_taken ? pc_q + imm_data : link;
        chk = br_taken;
      end
      3'b101:  tgt = csr_data_pc;
      3'b110: begin
        tgt = link;
        chk = 1'b0;
      end
      default: begin
        legal = 1'b0;
        chk   = 1'b0;
      end
    endcase
    mis = chk & (C_EXT ? tgt[0] : tgt[1]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ISSUE;
      out_valid     <= 1'b1;
      in_ready      <= 1'b0;
      pc_q          <= RESET_VEC;
      misalign      <= 1'b0;
      misalign_addr <= '0;
      illegal_sel   <= 1'b0;
    end else begin
      misalign    <= 1'b0;
      illegal_sel <= 1'b0;
      unique case (state_q)
        ISSUE: if (out_ready) begin
          state_q   <= WAIT;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        WAIT: if (in_valid) begin
          state_q   <= ISSUE;
          out_valid <= 1'b1;
          in_ready  <= 1'b0;
          if (!legal) begin
            illegal_sel <= 1'b1;
          end else if (mis) begin
            pc_q          <= mtvec;
            misalign      <= 1'b1;
            misalign_addr <= tgt;
          end else begin
            pc_q <= tgt;
          end
        end
        default: state_q <= ISSUE;
      endcase
    end
  end

  // Circular RAS: when full the write pointer sits on the oldest entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      ras_q        <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      ras_overflow <= 1'b0;
    end else if (accept) begin
      if (is_call && is_ret && cnt_q != '0) begin
        ras_q[top_idx] <= link;
      end else if (is_call) begin
        ras_q[ptr_q] <= link;
        ptr_q        <= ptr_q + PW'(1);
        if (cnt_q == FULL) ras_overflow <= 1'b1;
        else               cnt_q        <= cnt_q + CW'(1);
      end else if (is_ret && cnt_q != '0) begin
        ptr_q <= top_idx;
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign pc        = pc_q;
  assign ras_valid = (cnt_q != '0);
  assign ras_top   = ras_valid ? ras_q[top_idx] : '0;

endmodule

// File: tb/tb_ysyx_25030093_pc_gen.sv
// Directed + randomized bench for ysyx_25030093_pc_gen against a queue-based reference model.
module tb_ysyx_25030093_pc_gen;
  localparam int DEPTH = 4;
  localparam logic [31:0] RV = 32'h2000_0000;

  logic        clock = 1'b0;
  logic        reset, in_valid, in_ready, br_taken, is_call, is_ret;
  logic        out_valid, out_ready, misalign, illegal_sel, ras_valid, ras_overflow;
  logic [2:0]  pc_sel;
  logic [31:0] rs1_data, imm_data, csr_data_pc, mtvec, pc, misalign_addr, ras_top;

  ysyx_25030093_pc_gen #(.XLEN(32), .RESET_VEC(RV), .RAS_DEPTH(DEPTH), .C_EXT(1'b0)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pc_sel(pc_sel), .br_taken(br_taken), .rs1_data(rs1_data), .imm_data(imm_data),
    .csr_data_pc(csr_data_pc), .mtvec(mtvec), .is_call(is_call), .is_ret(is_ret),
    .out_valid(out_valid), .out_ready(out_ready), .pc(pc), .misalign(misalign),
    .misalign_addr(misalign_addr), .illegal_sel(illegal_sel), .ras_top(ras_top),
    .ras_valid(ras_valid), .ras_overflow(ras_overflow));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0] m_pc, m_maddr;
  logic        m_ovf, m_mis, m_ill;
  logic [31:0] m_ras[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_pc = RV; m_maddr = '0; m_ovf = 1'b0; m_mis = 1'b0; m_ill = 1'b0;
    m_ras.delete();
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    check({tag, ".misalign"}, 32'(misalign), 32'(m_mis));
    check({tag, ".illegal"}, 32'(illegal_sel), 32'(m_ill));
    check({tag, ".maddr"}, misalign_addr, m_maddr);
    check({tag, ".ras_valid"}, 32'(ras_valid), 32'(m_ras.size() != 0));
    check({tag, ".ras_top"}, ras_top, (m_ras.size() != 0) ? m_ras[$] : 32'd0);
    check({tag, ".ras_ovf"}, 32'(ras_overflow), 32'(m_ovf));
  endtask

  // One full fetch/commit round trip, starting and ending in ISSUE.
  task automatic commit(input string tag, input logic [2:0] sel, input logic bt,
                        input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] csr,
                        input logic call, input logic ret);
    logic [31:0] t, link;
    logic        chk;
    out_ready = 1'b1;
    cyc();
    check({tag, ".wait_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".wait_valid"}, 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    in_valid = 1'b1; pc_sel = sel; br_taken = bt; rs1_data = rs1; imm_data = imm;
    csr_data_pc = csr; is_call = call; is_ret = ret;
    cyc();
    in_valid = 1'b0; is_call = 1'b0; is_ret = 1'b0;
    // model
    link = m_pc + 32'd4;
    chk = 1'b1; m_ill = 1'b0; m_mis = 1'b0; t = m_pc;
    case (sel)
      3'b001: t = (rs1 + imm) & 32'hFFFF_FFFE;
      3'b010: t = m_pc + imm;
      3'b100: begin t = bt ? m_pc + imm : m_pc + 32'd4; chk = bt; end
      3'b101: t = csr;
      3'b110: begin t = m_pc + 32'd4; chk = 1'b0; end
      default: begin m_ill = 1'b1; chk = 1'b0; end
    endcase
    if (m_ill) ;
    else if (chk && t[1]) begin m_mis = 1'b1; m_maddr = t; m_pc = mtvec; end
    else m_pc = t;
    if (call && ret && m_ras.size() != 0) begin
      void'(m_ras.pop_back()); m_ras.push_back(link);
    end else if (call) begin
      m_ras.push_back(link);
      if (m_ras.size() > DEPTH) begin void'(m_ras.pop_front()); m_ovf = 1'b1; end
    end else if (ret && m_ras.size() != 0) begin
      void'(m_ras.pop_back());
    end
    check_state(tag);
    cyc();
    m_mis = 1'b0; m_ill = 1'b0;
    check_state({tag, ".after"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [2:0] sels[8];
    sels = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b000, 3'b011, 3'b111};
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pc_sel = 3'b110; br_taken = 1'b0;
    rs1_data = '0; imm_data = '0; csr_data_pc = '0; mtvec = 32'h8000_0000;
    is_call = 1'b0; is_ret = 1'b0;
    model_reset();
    cyc(); cyc();
    reset = 1'b0;
    check_state("reset");

    commit("seq", 3'b110, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    check("seq.pc_value", pc, 32'h2000_0004);

    // stall: in_valid during ISSUE must be ignored
    in_valid = 1'b1; pc_sel = 3'b010; imm_data = 32'h100;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_state("stall");
    end
    in_valid = 1'b0;

    commit("to100a", 3'b101, 1'b0, 0, 0, 32'h2000_0100, 1'b0, 1'b0);
    commit("jal", 3'b010, 1'b0, 0, 32'hFFFF_FF00, 0, 1'b0, 1'b0);
    check("jal.pc_value", pc, 32'h2000_0000);
    commit("to100b", 3'b101, 1'b0, 0, 0, 32'h2000_0100, 1'b0, 1'b0);
    commit("bnt", 3'b100, 1'b0, 0, 32'h40, 0, 1'b0, 1'b0);
    check("bnt.pc_value", pc, 32'h2000_0104);
    commit("to100c", 3'b101, 1'b0, 0, 0, 32'h2000_0100, 1'b0, 1'b0);
    commit("jalr_mis", 3'b001, 1'b0, 32'h2000_0203, 0, 0, 1'b0, 1'b0);
    check("jalr_mis.maddr_value", misalign_addr, 32'h2000_0202);
    commit("csr_mis", 3'b101, 1'b0, 0, 0, 32'h1000_0006, 1'b0, 1'b0);

    // RAS: five calls, five returns
    commit("to0", 3'b101, 1'b0, 0, 0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++)
      commit("call", 3'b101, 1'b0, 0, 0, 32'(i * 16), 1'b1, 1'b0);
    check("call.top_value", ras_top, 32'h44);
    check("call.ovf_value", 32'(ras_overflow), 32'd1);
    for (int i = 0; i < 5; i++)
      commit("ret", 3'b110, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    check("ret.empty", 32'(ras_valid), 32'd0);

    commit("illegal", 3'b011, 1'b0, 32'h55, 32'h66, 32'h77, 1'b0, 1'b0);
    commit("callret_empty", 3'b110, 1'b0, 0, 0, 0, 1'b1, 1'b1);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] imm;
      imm = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      commit("rand", sels[$urandom_range(0, 7)], 1'($urandom), $urandom, imm,
             $urandom & 32'hFFFF_FFFE, 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 2) == 0));
    end

    // reset during WAIT with a commit offered
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    in_valid = 1'b1; pc_sel = 3'b101; csr_data_pc = 32'h3000_0000; is_call = 1'b1;
    reset = 1'b1;
    cyc();
    reset = 1'b0; in_valid = 1'b0; is_call = 1'b0;
    model_reset();
    check_state("rst_wait");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
